// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM encoding, reset PC.
package instr_fetch_pkg;

  // 4-bit opcodes carried in Instr[15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Instruction fetch FSM encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC = 16'h0000;

  // Branch displacement: sign-extended 6-bit word offset turned into bytes
  function automatic logic [15:0] branch_offset(input logic [5:0] imm);
    return {{9{imm[5]}}, imm, 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus between the fetch unit and its memory / control-unit neighbours.
//
// Handshake: the fetch unit raises IMemReq with IMemAddr stable and keeps
// both unchanged until it samples IMemAck=1 on a rising edge; IMemData is
// taken on that same edge. IMemAck while IMemReq is low carries no meaning.
// InstrValid=1 means Instr/OPCODE/PC describe the instruction to execute;
// Stall=1 holds that instruction in place, Stall=0 retires it on the edge.
interface instr_fetch_if;
  logic        IMemReq;
  logic [15:0] IMemAddr;
  logic        IMemAck;
  logic [15:0] IMemData;
  logic        Stall;
  logic        Branch;
  logic        Zero;
  logic        Jump;
  logic [15:0] Instr;
  logic [3:0]  OPCODE;
  logic        InstrValid;
  logic [15:0] PC;
  logic        FetchErr;

  // Fetch unit side
  modport master (
    output IMemReq, IMemAddr, Instr, OPCODE, InstrValid, PC, FetchErr,
    input  IMemAck, IMemData, Stall, Branch, Zero, Jump
  );

  // Memory / control-unit side
  modport slave (
    input  IMemReq, IMemAddr, Instr, OPCODE, InstrValid, PC, FetchErr,
    output IMemAck, IMemData, Stall, Branch, Zero, Jump
  );
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selection: jump, taken branch or sequential.
module pc_next
  import instr_fetch_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [15:0] next_pc
);

  logic [15:0] pcp2;
  logic        unused_opcode;

  // Opcode bits are decoded by the control unit, not here
  assign unused_opcode = ^instr[15:12];

  // Jump wins over branch; all arithmetic wraps at 16 bits
  always_comb begin
    pcp2 = pc + 16'd2;
    if (jump) begin
      next_pc = {pcp2[15:13], instr[11:0], 1'b0};
    end else if (branch && zero) begin
      next_pc = pcp2 + branch_offset(instr[5:0]);
    end else begin
      next_pc = pcp2;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests the word at PC, holds it for execution,
// then advances PC. A memory that never answers sends the unit to HALT.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          ResetN,
  instr_fetch_if.master bus,
  output fetch_state_e  state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fetch_state_e  state;
  logic [15:0]   pc;
  logic [15:0]   instr;
  logic          imem_req;
  logic          instr_valid;
  logic          fetch_err;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   pc_nxt;

  pc_next u_pc_next (
    .pc      (pc),
    .instr   (instr),
    .branch  (bus.Branch),
    .zero    (bus.Zero),
    .jump    (bus.Jump),
    .next_pc (pc_nxt)
  );

  // Fetch FSM with registered request/valid/error outputs
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          // An ack on the final allowed cycle is still accepted
          if (bus.IMemAck) begin
            instr       <= bus.IMemData;
            state       <= S_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            wait_cnt  <= wait_cnt + 1'b1;
            state     <= S_HALT;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          // Stall freezes everything; branch inputs only matter on retire
          if (!bus.Stall) begin
            pc          <= pc_nxt;
            state       <= S_FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        S_HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.IMemReq    = imem_req;
  assign bus.IMemAddr   = pc;
  assign bus.Instr      = instr;
  assign bus.OPCODE     = instr[15:12];
  assign bus.InstrValid = instr_valid;
  assign bus.PC         = pc;
  assign bus.FetchErr   = fetch_err;
  assign state_dbg      = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch latency, stall, branch/jump
// targets, 16-bit wrap, ack-on-last-cycle, timeout to HALT and recovery.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic         Clock;
  logic         ResetN;
  fetch_state_e st;
  int           n_cmp;
  int           n_bad;
  logic [15:0]  a;
  logic [15:0]  tgt;

  instr_fetch_if bus ();

  instr_fetch #(.TIMEOUT(15)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .bus       (bus),
    .state_dbg (st)
  );

  // Clock and watchdog
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for a request, check its address, answer after dly cycles
  task automatic do_fetch(input logic [15:0] data, input int dly,
                          input logic [15:0] exp_addr, input string tag);
    int n;
    n = 0;
    while (bus.IMemReq !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check_eq({tag, "_req"}, 32'(bus.IMemReq), 32'd1);
    check_eq({tag, "_addr"}, 32'(bus.IMemAddr), 32'(exp_addr));
    repeat (dly) @(negedge Clock);
    bus.IMemAck  = 1'b1;
    bus.IMemData = data;
    @(negedge Clock);
    bus.IMemAck  = 1'b0;
    bus.IMemData = 16'h0000;
    check_eq({tag, "_valid"}, 32'(bus.InstrValid), 32'd1);
    check_eq({tag, "_instr"}, 32'(bus.Instr), 32'(data));
    check_eq({tag, "_opc"}, 32'(bus.OPCODE), 32'(data[15:12]));
  endtask

  // Retire the current instruction with the given decode inputs
  task automatic do_exec(input logic br, input logic z, input logic jmp);
    bus.Stall  = 1'b0;
    bus.Branch = br;
    bus.Zero   = z;
    bus.Jump   = jmp;
    @(negedge Clock);
    bus.Branch = 1'b0;
    bus.Zero   = 1'b0;
    bus.Jump   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ResetN       = 1'b0;
    bus.IMemAck  = 1'b0;
    bus.IMemData = 16'h0000;
    bus.Stall    = 1'b0;
    bus.Branch   = 1'b0;
    bus.Zero     = 1'b0;
    bus.Jump     = 1'b0;
    repeat (2) @(negedge Clock);

    check_eq("rst_state", 32'(st), 32'(S_IDLE));
    check_eq("rst_pc", 32'(bus.PC), 32'h0);
    check_eq("rst_instr", 32'(bus.Instr), 32'h0);
    check_eq("rst_opc", 32'(bus.OPCODE), 32'h0);
    check_eq("rst_valid", 32'(bus.InstrValid), 32'h0);
    check_eq("rst_req", 32'(bus.IMemReq), 32'h0);
    check_eq("rst_err", 32'(bus.FetchErr), 32'h0);
    ResetN = 1'b1;

    // First fetch, ack two cycles after the request
    do_fetch(16'h1234, 2, 16'h0000, "first");
    check_eq("first_state", 32'(st), 32'(S_EXEC));
    do_exec(1'b0, 1'b0, 1'b0);

    // Stall for 3 cycles; stray ack and jump must be ignored
    do_fetch(16'h5000, 0, 16'h0002, "stall");
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.IMemAck  = 1'b1;
        bus.IMemData = 16'hDEAD;
        bus.Jump     = 1'b1;
      end
      @(negedge Clock);
      bus.IMemAck  = 1'b0;
      bus.IMemData = 16'h0000;
      bus.Jump     = 1'b0;
      check_eq("stall_valid", 32'(bus.InstrValid), 32'd1);
      check_eq("stall_instr", 32'(bus.Instr), 32'h5000);
      check_eq("stall_pc", 32'(bus.PC), 32'h0002);
    end
    bus.Stall = 1'b0;
    @(negedge Clock);
    check_eq("unstall_pc", 32'(bus.PC), 32'h0004);

    // Forward branch: 0x0006 + 5*2 = 0x0010
    do_fetch(16'h0005, 1, 16'h0004, "br_fwd");
    do_exec(1'b1, 1'b1, 1'b0);
    // Backward branch taken: 0x0012 + (-2*2) = 0x000E
    do_fetch(16'hF3FE, 0, 16'h0010, "br_back");
    do_exec(1'b1, 1'b1, 1'b0);
    // Branch with Zero=0 falls through: 0x000E + 2 = 0x0010
    do_fetch(16'h0001, 0, 16'h000E, "br_nz_a");
    do_exec(1'b1, 1'b0, 1'b0);
    // Same 0xF3FE branch, Zero=0: 0x0012
    do_fetch(16'hF3FE, 0, 16'h0010, "br_nz_b");
    do_exec(1'b1, 1'b0, 1'b0);
    // Jump to end of region 0: {000, FFF, 0} = 0x1FFE
    do_fetch(16'h0FFF, 0, 16'h0012, "jmp0");
    do_exec(1'b0, 1'b0, 1'b1);
    do_fetch(16'h0000, 0, 16'h1FFE, "seq_a");
    do_exec(1'b0, 1'b0, 1'b0);
    do_fetch(16'h0000, 0, 16'h2000, "seq_b");
    do_exec(1'b0, 1'b0, 1'b0);
    do_fetch(16'h0000, 0, 16'h2002, "seq_c");
    do_exec(1'b0, 1'b0, 1'b0);
    // Jump beats branch: {001, 100, 0} = 0x2200
    do_fetch(16'h0100, 0, 16'h2004, "jmp_pri");
    do_exec(1'b1, 1'b1, 1'b1);

    // Climb through each 8 KiB region up to 0xFFFE, then wrap to 0
    a = 16'h2200;
    for (int r = 1; r < 8; r++) begin
      tgt = {r[2:0], 12'hFFF, 1'b0};
      do_fetch(16'hC0FF | 16'h0F00, r % 3, a, "climb_j");
      do_exec(1'b0, 1'b0, 1'b1);
      do_fetch(16'hE000, 0, tgt, "climb_s");
      do_exec(1'b0, 1'b0, 1'b0);
      a = tgt + 16'd2;
    end

    // Wrapped address; ack on the last cycle before timeout is accepted
    do_fetch(16'h7777, 14, a, "wrap_late_ack");
    check_eq("late_ack_err", 32'(bus.FetchErr), 32'd0);
    do_exec(1'b0, 1'b0, 1'b0);

    // Withhold ack: still fetching after 14 cycles, HALT after 15
    @(negedge Clock);
    check_eq("to_addr", 32'(bus.IMemAddr), 32'h0002);
    repeat (13) @(negedge Clock);
    check_eq("to_14_err", 32'(bus.FetchErr), 32'd0);
    check_eq("to_14_req", 32'(bus.IMemReq), 32'd1);
    @(negedge Clock);
    check_eq("to_15_err", 32'(bus.FetchErr), 32'd1);
    check_eq("to_15_req", 32'(bus.IMemReq), 32'd0);
    check_eq("to_15_valid", 32'(bus.InstrValid), 32'd0);
    check_eq("to_15_state", 32'(st), 32'(S_HALT));

    // Late ack in HALT changes nothing
    bus.IMemAck  = 1'b1;
    bus.IMemData = 16'hABCD;
    repeat (2) @(negedge Clock);
    check_eq("halt_instr", 32'(bus.Instr), 32'h7777);
    check_eq("halt_state", 32'(st), 32'(S_HALT));
    check_eq("halt_err", 32'(bus.FetchErr), 32'd1);
    check_eq("halt_req", 32'(bus.IMemReq), 32'd0);

    // Reset with ack still asserted clears everything
    ResetN = 1'b0;
    @(negedge Clock);
    check_eq("rst2_err", 32'(bus.FetchErr), 32'd0);
    check_eq("rst2_state", 32'(st), 32'(S_IDLE));
    check_eq("rst2_pc", 32'(bus.PC), 32'h0);
    check_eq("rst2_instr", 32'(bus.Instr), 32'h0);
    check_eq("rst2_req", 32'(bus.IMemReq), 32'd0);
    bus.IMemAck  = 1'b0;
    bus.IMemData = 16'h0000;
    ResetN = 1'b1;
    do_fetch(16'h9ABC, 1, 16'h0000, "post_rst");
    do_exec(1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    check_eq("post_rst_pc", 32'(bus.PC), 32'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
